// File: rtl/fwd_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
// Shared definitions for the forwarding / hazard controller of the 16-bit,
// 8-register, 5-stage core.
//   REG_BITS      : width of a register index
//   FWD_*         : execute-stage operand mux select encoding
//   idex_tag_t    : shadow tag for the ID/EX stage {v, rd, wr, load}
//   prod_tag_t    : shadow tag for later producer stages {v, rd, wr}
// ---------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

   localparam int REG_BITS = 3;

   // Operand select encoding seen by the execute stage; 2'b11 is never driven.
   localparam logic [1:0] FWD_REG   = 2'b00;  // register file / immediate
   localparam logic [1:0] FWD_MEMWB = 2'b01;  // data_mem_from_mem_wb
   localparam logic [1:0] FWD_EXMEM = 2'b10;  // ALU_result_from_ex_mem

   typedef struct packed {
      logic                v;
      logic [REG_BITS-1:0] rd;
      logic                wr;
      logic                load;
   } idex_tag_t;

   // Once an instruction is past EX its load flag no longer matters.
   typedef struct packed {
      logic                v;
      logic [REG_BITS-1:0] rd;
      logic                wr;
   } prod_tag_t;

endpackage

// File: rtl/fwd_sel_cmp.sv
// ---------------------------------------------------------------------------
// fwd_sel_cmp
// Maps one decode-stage source operand to the forward select it will need
// when it reaches EX, given the producers that will then occupy EX/MEM
// (today's ID/EX) and MEM/WB (today's EX/MEM).
//   src       in  : source register index
//   src_valid in  : the instruction really reads this operand
//   idex      in  : current ID/EX tag (becomes EX/MEM producer)
//   exmem     in  : current EX/MEM tag (becomes MEM/WB producer)
//   sel       out : FWD_EXMEM / FWD_MEMWB / FWD_REG
// ---------------------------------------------------------------------------
module fwd_sel_cmp
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic [REG_BITS-1:0] src,
   input  logic                src_valid,
   input  idex_tag_t           idex,
   input  prod_tag_t           exmem,
   output logic [1:0]          sel
);

   always_comb begin
      // NOTE: default first so every path assigns sel and no latch is inferred.
      sel = FWD_REG;
      // A load in ID/EX cannot forward from EX/MEM: its data is not ready
      // yet, which is exactly the load-use case that stalls instead.
      if (src_valid && idex.v && idex.wr && !idex.load && (src == idex.rd))
         sel = FWD_EXMEM;
      else if (src_valid && exmem.v && exmem.wr && (src == exmem.rd))
         sel = FWD_MEMWB;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller. Tracks destination tags of the
// instructions behind decode and registers the ALU operand selects as each
// instruction enters EX. Register index width comes from the package.
//   clk, rst              : core clock, synchronous active-low reset
//   id_*                  : decode-stage instruction fields
//   mem_stall             : global freeze, all state holds
//   flush                 : taken branch/jump, squashes decode
//   forwardA, forwardB    : registered ALU input selects
//   stall_if_id           : hold PC and IF/ID
//   bubble_id_ex          : load a NOP into ID/EX
//   stall_count           : saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic                id_rs_valid,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_rt_valid,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_wr,
   input  logic                id_load,
   input  logic                mem_stall,
   input  logic                flush,
   output logic [1:0]          forwardA,
   output logic [1:0]          forwardB,
   output logic                stall_if_id,
   output logic                bubble_id_ex,
   output logic [CNT_W-1:0]    stall_count
);

   // Only ID/EX and EX/MEM tags are stored: the MEM/WB select is fixed at
   // decode time from the EX/MEM tag, so the tag of the instruction sitting
   // in MEM/WB is never compared again and would be dead state.
   idex_tag_t  idex;
   prod_tag_t  exmem;
   logic [1:0] sel_a, sel_b;
   logic       lu;

   assign lu = id_valid && idex.v && idex.wr && idex.load &&
               ((id_rs_valid && (id_rs == idex.rd)) ||
                (id_rt_valid && (id_rt == idex.rd)));

   // A flush kills the decode instruction, so its hazard no longer matters.
   assign stall_if_id  = lu && !flush;
   assign bubble_id_ex = (lu || flush) && !mem_stall;

   fwd_sel_cmp u_sel_a (
      .src       (id_rs),
      .src_valid (id_rs_valid),
      .idex      (idex),
      .exmem     (exmem),
      .sel       (sel_a)
   );

   fwd_sel_cmp u_sel_b (
      .src       (id_rt),
      .src_valid (id_rt_valid),
      .idex      (idex),
      .exmem     (exmem),
      .sel       (sel_b)
   );

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      // NOTE: only the few tag/control flops here, so all of them reset.
      if (!rst) begin
         idex        <= '0;
         exmem       <= '0;
         forwardA    <= FWD_REG;
         forwardB    <= FWD_REG;
         stall_count <= '0;
      end else if (!mem_stall) begin
         exmem <= '{v: idex.v, rd: idex.rd, wr: idex.wr};
         if (bubble_id_ex) begin
            idex     <= '0;
            forwardA <= FWD_REG;
            forwardB <= FWD_REG;
         end else begin
            idex     <= '{v: id_valid, rd: id_rd, wr: id_wr, load: id_load};
            forwardA <= sel_a;
            forwardB <= sel_b;
         end
         if (stall_if_id && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

endmodule
